// File: rtl/text_display_buffer_pkg.sv
// Shared types and default geometry for the text display buffer.
package display_pkg;
  localparam int CHARS_HORZ_DFLT = 80;
  localparam int CHARS_VERT_DFLT = 30;
  localparam int ASCII_SIZE_DFLT = 8;
  localparam int ROW_W_DFLT      = $clog2(CHARS_VERT_DFLT);
  localparam int COL_W_DFLT      = $clog2(CHARS_HORZ_DFLT);

  localparam logic [7:0] FILL_CHAR_DFLT = 8'h20;
  localparam logic [7:0] NL             = 8'h0A;
  localparam logic [7:0] CR             = 8'h0D;

  typedef enum logic [1:0] {
    PUT     = 2'd0,
    SET_CUR = 2'd1,
    CLEAR   = 2'd2,
    RSVD    = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CLEAR_ALL   = 2'd1,
    SCROLL_FILL = 2'd2
  } state_t;
endpackage

// File: rtl/text_display_buffer_if.sv
// Processor-side command port: valid/ready handshake carrying one terminal command.
interface text_display_buffer_if #(
  parameter int ASCII_SIZE = display_pkg::ASCII_SIZE_DFLT,
  parameter int ROW_W      = display_pkg::ROW_W_DFLT,
  parameter int COL_W      = display_pkg::COL_W_DFLT
);
  import display_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  cmd_op_t               cmd_op;
  logic [ASCII_SIZE-1:0] cmd_char;
  logic [ROW_W-1:0]      cmd_row;
  logic [COL_W-1:0]      cmd_col;

  modport master (output cmd_valid, cmd_op, cmd_char, cmd_row, cmd_col, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_char, cmd_row, cmd_col, output cmd_ready);
endinterface

// File: rtl/text_display_buffer_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
module text_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2400,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Read-before-write: a same-cycle read of the written cell sees the old value.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/text_display_buffer.sv
// Terminal-style character display memory with cursor, wrap, newline and hardware scroll.
//   state       | meaning
//   IDLE        | accepting commands
//   CLEAR_ALL   | filling every cell with FILL_CHAR, one per cycle
//   SCROLL_FILL | filling the new bottom row after a scroll
module text_display_buffer
  import display_pkg::*;
#(
  parameter int CHARS_HORZ = CHARS_HORZ_DFLT,
  parameter int CHARS_VERT = CHARS_VERT_DFLT,
  parameter int ASCII_SIZE = ASCII_SIZE_DFLT,
  parameter logic [ASCII_SIZE-1:0] FILL_CHAR = ASCII_SIZE'(FILL_CHAR_DFLT),
  localparam int ROW_W = $clog2(CHARS_VERT),
  localparam int COL_W = $clog2(CHARS_HORZ)
) (
  input  logic                  clk,
  input  logic                  RESET,
  text_display_buffer_if.slave  cmd,
  input  logic [ROW_W-1:0]      rd_row,
  input  logic [COL_W-1:0]      rd_col,
  output logic [ASCII_SIZE-1:0] rd_char,
  output logic [ROW_W-1:0]      cur_row,
  output logic [COL_W-1:0]      cur_col,
  output logic                  busy
);
  localparam int CELLS  = CHARS_HORZ * CHARS_VERT;
  localparam int ADDR_W = $clog2(CELLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CHARS_VERT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CHARS_HORZ - 1);

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d, base_q, base_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  busy_q, busy_d, ready_q, ready_d;
  logic                  rd_en_q, rd_en_d, rd_oob_q, rd_oob_d;
  logic                  we, advance;
  logic [ADDR_W-1:0]     wr_addr, rd_addr;
  logic [ASCII_SIZE-1:0] wr_data, ram_rd_data;

  // Logical row is rotated by row_base with an explicit wrap; CHARS_VERT need not be a power of two.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] base);
    logic [ROW_W:0] phys;
    phys = {1'b0, row} + {1'b0, base};
    if (phys >= (ROW_W+1)'(CHARS_VERT)) phys = phys - (ROW_W+1)'(CHARS_VERT);
    return ADDR_W'(phys) * ADDR_W'(CHARS_HORZ) + ADDR_W'(col);
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    advance = 1'b0;
    wr_addr = cell_addr(row_q, col_q, base_q);
    wr_data = cmd.cmd_char;
    case (state_q)
      IDLE: if (cmd.cmd_valid && ready_q) begin
        case (cmd.cmd_op)
          PUT: begin
            if (cmd.cmd_char == ASCII_SIZE'(NL)) begin
              col_d   = '0;
              advance = 1'b1;
            end else if (cmd.cmd_char == ASCII_SIZE'(CR)) begin
              col_d = '0;
            end else begin
              we = 1'b1;
              if (col_q == COL_LAST) begin
                col_d   = '0;
                advance = 1'b1;
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end
          end
          SET_CUR: begin
            row_d = (cmd.cmd_row > ROW_LAST) ? ROW_LAST : cmd.cmd_row;
            col_d = (cmd.cmd_col > COL_LAST) ? COL_LAST : cmd.cmd_col;
          end
          CLEAR: begin
            row_d   = '0;
            col_d   = '0;
            base_d  = '0;
            cnt_d   = ADDR_W'(CELLS - 1);
            state_d = CLEAR_ALL;
          end
          default: ;
        endcase
        if (advance) begin
          if (row_q != ROW_LAST) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            base_d  = (base_q == ROW_LAST) ? '0 : base_q + ROW_W'(1);
            cnt_d   = ADDR_W'(CHARS_HORZ - 1);
            state_d = SCROLL_FILL;
          end
        end
      end
      // busy_q stays low for the first cycle after reset so the fill lasts exactly its cell count.
      CLEAR_ALL, SCROLL_FILL: if (busy_q) begin
        we      = 1'b1;
        wr_data = FILL_CHAR;
        if (state_q == CLEAR_ALL) wr_addr = ADDR_W'(CELLS - 1) - cnt_q;
        else wr_addr = cell_addr(ROW_LAST, '0, base_q) + ADDR_W'(CHARS_HORZ - 1) - cnt_q;
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    ready_d  = (state_d == IDLE);
    rd_en_d  = 1'b1;
    rd_oob_d = ({1'b0, rd_row} >= (ROW_W+1)'(CHARS_VERT)) ||
               ({1'b0, rd_col} >= (COL_W+1)'(CHARS_HORZ));
    rd_addr  = cell_addr(rd_row, rd_col, base_q);
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q  <= CLEAR_ALL;
      row_q    <= '0;
      col_q    <= '0;
      base_q   <= '0;
      cnt_q    <= ADDR_W'(CELLS - 1);
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_oob_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      rd_en_q  <= rd_en_d;
      rd_oob_q <= rd_oob_d;
    end
  end

  text_ram #(.DATA_W(ASCII_SIZE), .DEPTH(CELLS), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (we & RESET),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  assign rd_char       = !rd_en_q ? '0 : (rd_oob_q ? FILL_CHAR : ram_rd_data);
  assign cur_row       = row_q;
  assign cur_col       = col_q;
  assign busy          = busy_q;
  assign cmd.cmd_ready = ready_q;
endmodule

// File: tb/tb_text_display_buffer.sv
// Directed bench for text_display_buffer at 8x4, plus clear length and clamping at 80x30.
module tb_text_display_buffer;
  import display_pkg::*;

  localparam int H   = 8;
  localparam int V   = 4;
  localparam int RW  = $clog2(V);
  localparam int CW  = $clog2(H);
  localparam int BH  = 80;
  localparam int BV  = 30;
  localparam int BRW = $clog2(BV);
  localparam int BCW = $clog2(BH);

  logic clk = 1'b0;
  logic rst_b, rst_big_b;
  logic [RW-1:0]  rd_row, cur_row;
  logic [CW-1:0]  rd_col, cur_col;
  logic [7:0]     rd_char, rd_char_b;
  logic           busy, busy_b;
  logic [BRW-1:0] rd_row_b, cur_row_b;
  logic [BCW-1:0] rd_col_b, cur_col_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  text_display_buffer_if #(.ASCII_SIZE(8), .ROW_W(RW),  .COL_W(CW))  cmd_s ();
  text_display_buffer_if #(.ASCII_SIZE(8), .ROW_W(BRW), .COL_W(BCW)) cmd_b ();

  text_display_buffer #(.CHARS_HORZ(H), .CHARS_VERT(V), .ASCII_SIZE(8), .FILL_CHAR(8'h20)) dut (
    .clk(clk), .RESET(rst_b), .cmd(cmd_s), .rd_row(rd_row), .rd_col(rd_col),
    .rd_char(rd_char), .cur_row(cur_row), .cur_col(cur_col), .busy(busy));

  text_display_buffer #(.CHARS_HORZ(BH), .CHARS_VERT(BV), .ASCII_SIZE(8), .FILL_CHAR(8'h20)) dut_big (
    .clk(clk), .RESET(rst_big_b), .cmd(cmd_b), .rd_row(rd_row_b), .rd_col(rd_col_b),
    .rd_char(rd_char_b), .cur_row(cur_row_b), .cur_col(cur_col_b), .busy(busy_b));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input cmd_op_t op, input logic [7:0] ch, input int row, input int col,
                      output int waited);
    waited = 0;
    cmd_s.cmd_valid = 1'b1;
    cmd_s.cmd_op    = op;
    cmd_s.cmd_char  = ch;
    cmd_s.cmd_row   = RW'(row);
    cmd_s.cmd_col   = CW'(col);
    while (!cmd_s.cmd_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("cmd_accept", 32'(cmd_s.cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_s.cmd_valid = 1'b0;
  endtask

  task automatic send_big(input cmd_op_t op, input logic [7:0] ch, input int row, input int col);
    cmd_b.cmd_valid = 1'b1;
    cmd_b.cmd_op    = op;
    cmd_b.cmd_char  = ch;
    cmd_b.cmd_row   = BRW'(row);
    cmd_b.cmd_col   = BCW'(col);
    check("big_cmd_accept", 32'(cmd_b.cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_b.cmd_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    int guard;
    guard = 0;
    n = 0;
    while (!cmd_s.cmd_ready && guard < 200) begin
      if (busy) n++;
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic check_cell(input int r, input int c, input logic [7:0] exp);
    rd_row = RW'(r);
    rd_col = CW'(c);
    @(posedge clk); #1;
    check($sformatf("cell_r%0d_c%0d", r, c), 32'(rd_char), 32'(exp));
  endtask

  task automatic check_cursor(input int r, input int c);
    check("cur_row", 32'(cur_row), 32'(r));
    check("cur_col", 32'(cur_col), 32'(c));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, w, guard;
    rst_b = 1'b0;
    rst_big_b = 1'b0;
    cmd_s.cmd_valid = 1'b0; cmd_s.cmd_op = PUT; cmd_s.cmd_char = '0;
    cmd_s.cmd_row = '0; cmd_s.cmd_col = '0;
    cmd_b.cmd_valid = 1'b0; cmd_b.cmd_op = PUT; cmd_b.cmd_char = '0;
    cmd_b.cmd_row = '0; cmd_b.cmd_col = '0;
    rd_row = '0; rd_col = '0; rd_row_b = '0; rd_col_b = '0;

    // 1: reset values, clear length, every cell filled
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_s.cmd_ready), 32'd0);
    check("rst_rd_char", 32'(rd_char), 32'd0);
    check_cursor(0, 0);
    rst_b = 1'b1;
    count_busy(n);
    check("clear_busy_cycles", 32'(n), 32'd32);
    check("ready_after_clear", 32'(cmd_s.cmd_ready), 32'd1);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) check_cell(r, c, 8'h20);

    // 2: put, read latency, same-cycle read of written cell
    rd_row = '0; rd_col = '0;
    send(PUT, 8'h41, 0, 0, w);
    check("rd_old_on_collision", 32'(rd_char), 32'h20);
    @(posedge clk); #1;
    check("rd_put_41", 32'(rd_char), 32'h41);
    check_cursor(0, 1);

    // 3: line wrap, newline, carriage return
    send(SET_CUR, 8'h00, 0, 0, w);
    for (int i = 0; i < H; i++) send(PUT, 8'h30 + 8'(i), 0, 0, w);
    check_cursor(1, 0);
    for (int c = 0; c < H; c++) check_cell(0, c, 8'h30 + 8'(c));
    send(SET_CUR, 8'h00, 1, 3, w);
    send(PUT, 8'h0A, 0, 0, w);
    check_cursor(2, 0);
    check_cell(1, 3, 8'h20);
    send(SET_CUR, 8'h00, 2, 5, w);
    send(PUT, 8'h0D, 0, 0, w);
    check_cursor(2, 0);
    check_cell(2, 5, 8'h20);

    // 4: write at bottom-right scrolls
    send(SET_CUR, 8'h00, 1, 0, w);
    send(PUT, 8'h42, 0, 0, w);
    send(PUT, 8'h43, 0, 0, w);
    send(SET_CUR, 8'h00, 3, 7, w);
    send(PUT, 8'h5A, 0, 0, w);
    count_busy(n);
    check("scroll_busy_cycles", 32'(n), 32'd8);
    check_cursor(3, 0);
    for (int c = 0; c < H; c++) check_cell(3, c, 8'h20);
    check_cell(0, 0, 8'h42);
    check_cell(0, 1, 8'h43);
    check_cell(0, 2, 8'h20);
    check_cell(2, 7, 8'h5A);
    check_cell(1, 0, 8'h20);

    // 5: clamped set cursor, reserved op, command held while busy
    send(SET_CUR, 8'h00, 7, 15, w);
    check_cursor(3, 7);
    send(RSVD, 8'hFF, 0, 0, w);
    check_cursor(3, 7);
    check("rsvd_busy", 32'(busy), 32'd0);
    check("rsvd_ready", 32'(cmd_s.cmd_ready), 32'd1);
    check_cell(2, 7, 8'h5A);
    send(CLEAR, 8'h00, 0, 0, w);
    send(PUT, 8'h61, 0, 0, w);
    check("held_wait_cycles", 32'(w), 32'd32);
    check_cursor(0, 1);
    check_cell(0, 0, 8'h61);
    check_cell(0, 1, 8'h20);
    check_cell(3, 7, 8'h20);

    // 6: reset in the middle of a clear restarts it
    send(SET_CUR, 8'h00, 3, 5, w);
    send(PUT, 8'h77, 0, 0, w);
    check_cell(3, 5, 8'h77);
    send(CLEAR, 8'h00, 0, 0, w);
    repeat (9) begin @(posedge clk); #1; end
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_s.cmd_ready), 32'd0);
    check("midrst_rd_char", 32'(rd_char), 32'd0);
    check_cursor(0, 0);
    rst_b = 1'b1;
    count_busy(n);
    check("midrst_clear_cycles", 32'(n), 32'd32);
    check_cell(3, 5, 8'h20);
    check_cell(0, 0, 8'h20);

    // 80x30: clear length, cursor clamp, out-of-range read
    rst_big_b = 1'b1;
    n = 0;
    guard = 0;
    while (!cmd_b.cmd_ready && guard < 3000) begin
      if (busy_b) n++;
      @(posedge clk); #1;
      guard++;
    end
    check("big_clear_cycles", 32'(n), 32'd2400);
    send_big(SET_CUR, 8'h00, 31, 127);
    check("big_clamp_row", 32'(cur_row_b), 32'd29);
    check("big_clamp_col", 32'(cur_col_b), 32'd79);
    send_big(SET_CUR, 8'h00, 0, 0);
    send_big(PUT, 8'h55, 0, 0);
    rd_row_b = '0; rd_col_b = '0;
    @(posedge clk); #1;
    check("big_rd_0_0", 32'(rd_char_b), 32'h55);
    rd_row_b = BRW'(30);
    @(posedge clk); #1;
    check("big_rd_oob_row", 32'(rd_char_b), 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
